// File: rtl/irrigation_phase_timer.sv
// Per-phase countdown for the irrigation controller.
// Counts prescaled ticks and pulses time_over when a phase expires.
module irrigation_phase_timer #(
  parameter int TICK_DIV      = 50000000,
  parameter int CNT_W         = 8,
  parameter int DUR_FILL      = 30,
  parameter int DUR_SPRINKLER = 60,
  parameter int DUR_DRIP      = 120,
  parameter int DUR_CLEAN     = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       state,
  output logic             time_over,
  output logic [CNT_W-1:0] remaining,
  output logic             tick,
  output logic             busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Truncate first, then lift zero to one so a phase never starts expired.
  localparam logic [CNT_W-1:0] T_FILL = CNT_W'(DUR_FILL);
  localparam logic [CNT_W-1:0] T_SPRK = CNT_W'(DUR_SPRINKLER);
  localparam logic [CNT_W-1:0] T_DRIP = CNT_W'(DUR_DRIP);
  localparam logic [CNT_W-1:0] T_CLN  = CNT_W'(DUR_CLEAN);
  localparam logic [CNT_W-1:0] D_FILL = (T_FILL == '0) ? ONE : T_FILL;
  localparam logic [CNT_W-1:0] D_SPRK = (T_SPRK == '0) ? ONE : T_SPRK;
  localparam logic [CNT_W-1:0] D_DRIP = (T_DRIP == '0) ? ONE : T_DRIP;
  localparam logic [CNT_W-1:0] D_CLN  = (T_CLN == '0) ? ONE : T_CLN;

  function automatic logic [CNT_W-1:0] dur(input logic [1:0] s);
    case (s)
      2'b00:   dur = D_FILL;
      2'b01:   dur = D_SPRK;
      2'b10:   dur = D_DRIP;
      default: dur = D_CLN;
    endcase
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             tover_q, tover_d;
  logic             tick_q, tick_d;

  always_comb begin
    presc_d = presc_q;
    state_d = state_q;
    rem_d   = rem_q;
    tover_d = 1'b0;
    tick_d  = 1'b0;
    // Reload after expiry even when the phase is unchanged.
    if (tover_q || (state != state_q)) begin
      rem_d   = dur(state);
      state_d = state;
      presc_d = '0;
    end else if (enable) begin
      if (presc_q == P_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (rem_q == ONE) begin
          rem_d   = '0;
          tover_d = 1'b1;
        end else if (rem_q != '0) begin
          rem_d = rem_q - ONE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q <= '0;
      state_q <= 2'b00;
      rem_q   <= D_FILL;
      tover_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      tover_q <= tover_d;
      tick_q  <= tick_d;
    end
  end

  assign time_over = tover_q;
  assign remaining = rem_q;
  assign tick      = tick_q;
  assign busy      = (rem_q != '0);

endmodule

// File: tb/tb_irrigation_phase_timer.sv
// Scoreboard bench for irrigation_phase_timer.
// Small TICK_DIV and durations keep every phase short.
module tb_irrigation_phase_timer;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [1:0] state;
  logic       time_over;
  logic [7:0] remaining;
  logic       tick;
  logic       busy;

  typedef struct packed {
    logic [7:0] rem;
    logic       tov;
    logic       tk;
    logic       bsy;
  } obs_t;

  obs_t exp_q[$];
  obs_t got;
  obs_t want;
  int   checks = 0;
  int   passes = 0;

  irrigation_phase_timer #(
    .TICK_DIV(4),
    .CNT_W(8),
    .DUR_FILL(3),
    .DUR_SPRINKLER(5),
    .DUR_DRIP(7),
    .DUR_CLEAN(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .state(state),
    .time_over(time_over),
    .remaining(remaining),
    .tick(tick),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t mk(int r, bit tov, bit tk);
    obs_t o;
    o.rem = 8'(r);
    o.tov = tov;
    o.tk  = tk;
    o.bsy = (r != 0);
    return o;
  endfunction

  // Fresh fill phase (D=3) counted from reset release.
  function automatic obs_t fill_at(int k);
    return mk(3 - k / 4, k == 12, (k % 4) == 0);
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rem=%0d tov=%b tick=%b busy=%b",
                     o.rem, o.tov, o.tk, o.bsy);
  endfunction

  task automatic edge_();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    state   = 2'b00;
    edge_();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    state   = 2'b11;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(mk(3, 1'b0, 1'b0));
      edge_();
      got  = {remaining, time_over, tick, busy};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL reset[%0d]: got %s want %s",
                 k, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_fill_countdown();
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      exp_q.push_back(k <= 12 ? fill_at(k) : mk(3, 1'b0, 1'b0));
      edge_();
      got  = {remaining, time_over, tick, busy};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL fill[%0d]: got %s want %s",
                 k, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_phase_sequence();
    int         durs[4];
    logic [1:0] sts[4];
    int         pulses;
    durs   = '{3, 5, 2, 3};
    sts    = '{2'b00, 2'b01, 2'b11, 2'b00};
    pulses = 0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int t = (p == 0) ? 1 : 0; t <= 4 * durs[p]; t++) begin
        state = sts[p];
        exp_q.push_back(mk(durs[p] - t / 4, t == 4 * durs[p],
                           t != 0 && (t % 4) == 0));
        edge_();
        if (time_over) pulses++;
        got  = {remaining, time_over, tick, busy};
        want = exp_q.pop_front();
        checks++;
        if (got !== want)
          $display("FAIL seq[p%0d t%0d]: got %s want %s",
                   p, t, fmt(got), fmt(want));
        else passes++;
      end
    end
    checks++;
    if (pulses !== 4)
      $display("FAIL seq_pulses: got %0d want 4", pulses);
    else passes++;
  endtask

  task automatic test_enable_freeze();
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      enable = !(k >= 6 && k <= 15);
      if (k <= 5)       exp_q.push_back(fill_at(k));
      else if (k <= 17) exp_q.push_back(mk(2, 1'b0, 1'b0));
      else              exp_q.push_back(mk(1, 1'b0, 1'b1));
      edge_();
      got  = {remaining, time_over, tick, busy};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL freeze[%0d]: got %s want %s",
                 k, fmt(got), fmt(want));
      else passes++;
    end
    enable = 1'b1;
  endtask

  task automatic test_phase_change();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      state = (k >= 5) ? 2'b10 : 2'b00;
      if (k <= 4)      exp_q.push_back(fill_at(k));
      else if (k <= 8) exp_q.push_back(mk(7, 1'b0, 1'b0));
      else             exp_q.push_back(mk(6, 1'b0, 1'b1));
      edge_();
      got  = {remaining, time_over, tick, busy};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL change[%0d]: got %s want %s",
                 k, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_change_on_final_tick();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      state = (k >= 12) ? 2'b11 : 2'b00;
      if (k <= 11)      exp_q.push_back(fill_at(k));
      else if (k <= 15) exp_q.push_back(mk(2, 1'b0, 1'b0));
      else              exp_q.push_back(mk(1, 1'b0, 1'b1));
      edge_();
      got  = {remaining, time_over, tick, busy};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL final_tick[%0d]: got %s want %s",
                 k, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_reset_during_pulse();
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      reset_n = (k != 13);
      state   = (k >= 13) ? 2'b01 : 2'b00;
      if (k <= 12)      exp_q.push_back(fill_at(k));
      else if (k == 13) exp_q.push_back(mk(3, 1'b0, 1'b0));
      else if (k <= 17) exp_q.push_back(mk(5, 1'b0, 1'b0));
      else              exp_q.push_back(mk(4, 1'b0, 1'b1));
      edge_();
      got  = {remaining, time_over, tick, busy};
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
        $display("FAIL rst_pulse[%0d]: got %s want %s",
                 k, fmt(got), fmt(want));
      else passes++;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    state   = 2'b00;
    test_reset();
    test_fill_countdown();
    test_phase_sequence();
    test_enable_freeze();
    test_phase_change();
    test_change_on_final_tick();
    test_reset_during_pulse();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
